mem_dump_tx: RTL and testbench

- Read-back counterpart to the pushbutton front end that loads operands into data RAM.
- After the CPU finishes, it reads a block of data-memory words through the RAM's data-port read path and serialises them byte by byte onto the board UART transmit interface (txdata/txclk/txready).
- Sits beside the FPGA calculator module in the top level and shares the data-port address/read-enable muxes.

---
 rtl/mem_dump_tx.sv | 162 ++++++++++++++++
 tb/tb_mem_dump_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_tx.sv
// Reads a block of data-RAM words and streams them little-endian, one byte per
// UART load strobe. Optional trailing XOR checksum byte: define MEMDUMP_CHECKSUM_EN.
module mem_dump_tx #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  output logic [7:0]        txdata,
  output logic              txclk,
  input  logic              txready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        o_dbg_state
);

  // UART handshake: a byte is offered only when txready is sampled high in
  // SEND/CHECK; txclk is then a one-cycle strobe with txdata stable, and the
  // following HOLD cycle never strobes, giving the UART time to drop txready.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_HOLD    = 3'd4,
    S_FINISH  = 3'd5,
    S_CHECK   = 3'd6
  } state_t;

`ifdef MEMDUMP_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CHECK;
`else
  localparam state_t S_AFTER_DATA = S_FINISH;
`endif

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_remain;
  logic [1:0]        r_idx;
  logic [31:0]       r_buf;
  logic [7:0]        r_txdata;
  logic              r_txclk;
  logic              r_rd_en;
  logic              r_busy;
  logic              r_done;
`ifdef MEMDUMP_CHECKSUM_EN
  logic [7:0]        r_csum;
  logic              r_csum_sent;
`endif

  logic [7:0] w_byte;
  assign w_byte = r_buf[{r_idx, 3'b000} +: 8];

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remain    <= '0;
      r_idx       <= '0;
      r_buf       <= '0;
      r_txdata    <= '0;
      r_txclk     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef MEMDUMP_CHECKSUM_EN
      r_csum      <= '0;
      r_csum_sent <= 1'b0;
`endif
    end else begin
      r_txclk <= 1'b0;
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr   <= base_addr & ~ADDR_W'(3);
            r_remain <= word_count;
            r_idx    <= '0;
            r_busy   <= 1'b1;
`ifdef MEMDUMP_CHECKSUM_EN
            r_csum      <= '0;
            r_csum_sent <= 1'b0;
`endif
            if (word_count == '0) begin
              r_state <= S_AFTER_DATA;
            end else begin
              r_rd_en <= 1'b1;
              r_state <= S_READ;
            end
          end
        end
        S_READ: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          // RAM data_out is valid one cycle after the read request.
          r_buf   <= mem_data;
          r_idx   <= '0;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (txready) begin
            r_txdata <= w_byte;
            r_txclk  <= 1'b1;
`ifdef MEMDUMP_CHECKSUM_EN
            r_csum   <= r_csum ^ w_byte;
`endif
            r_state  <= S_HOLD;
          end
        end
        S_HOLD: begin
`ifdef MEMDUMP_CHECKSUM_EN
          if (r_csum_sent) begin
            r_state <= S_FINISH;
          end else
`endif
          if (r_idx != 2'd3) begin
            r_idx   <= r_idx + 2'd1;
            r_state <= S_SEND;
          end else if (r_remain > CNT_W'(1)) begin
            r_addr   <= r_addr + ADDR_W'(4);
            r_remain <= r_remain - CNT_W'(1);
            r_rd_en  <= 1'b1;
            r_state  <= S_READ;
          end else begin
            r_state <= S_AFTER_DATA;
          end
        end
`ifdef MEMDUMP_CHECKSUM_EN
        S_CHECK: begin
          if (txready) begin
            r_txdata    <= r_csum;
            r_txclk     <= 1'b1;
            r_csum_sent <= 1'b1;
            r_state     <= S_HOLD;
          end
        end
`endif
        S_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_read_en = r_rd_en;
  assign mem_addr    = r_addr;
  assign txdata      = r_txdata;
  assign txclk       = r_txclk;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Self-checking bench for mem_dump_tx: directed cases plus random dumps
// compared against a word/byte-level reference model of the dump stream.
module tb_mem_dump_tx;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 6;

  logic              clk = 1'b0;
  logic              nRST = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              mem_read_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data = '0;
  logic [7:0]        txdata;
  logic              txclk;
  logic              txready = 1'b1;
  logic              busy;
  logic              done;
  logic [2:0]        dbg_state;

  mem_dump_tx #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .nRST(nRST), .start(start), .base_addr(base_addr),
    .word_count(word_count), .mem_read_en(mem_read_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .txdata(txdata), .txclk(txclk), .txready(txready),
    .busy(busy), .done(done), .o_dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model with one-cycle read latency
  logic [31:0] ram [0:1023];
  always @(posedge clk) if (mem_read_en) mem_data <= ram[mem_addr[ADDR_W-1:2]];

  // monitor: record strobed bytes, read addresses and done pulses
  logic [7:0]        got_b[$];
  int                got_t[$];
  logic [ADDR_W-1:0] got_a[$];
  int                done_cnt = 0;
  int                done_cyc = 0;
  always @(negedge clk) begin
    if (nRST) begin
      if (txclk) begin got_b.push_back(txdata); got_t.push_back(cyc); end
      if (mem_read_en) got_a.push_back(mem_addr);
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  // scoreboard
  logic [7:0]        exp_q[$];
  logic [ADDR_W-1:0] exp_a[$];
  int n_tests = 0;
  int n_fail  = 0;
  int start_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: expected read addresses and byte stream
  task automatic build_exp(input logic [ADDR_W-1:0] base, input int wc);
    logic [ADDR_W-1:0] a;
    logic [31:0] word;
    logic [7:0] csum;
    exp_q.delete(); exp_a.delete();
    a = base & 12'hFFC;
    csum = 8'h00;
    for (int w = 0; w < wc; w++) begin
      exp_a.push_back(a);
      word = ram[a / 4];
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(word[8*b +: 8]);
        csum = csum ^ word[8*b +: 8];
      end
      a = a + 12'd4;
    end
`ifdef MEMDUMP_CHECKSUM_EN
    exp_q.push_back(csum);
`endif
  endtask

  task automatic clear_mon();
    got_b.delete(); got_t.delete(); got_a.delete();
  endtask

  task automatic compare_sb(input string tag);
    int nb, na;
    nb = (got_b.size() < exp_q.size()) ? got_b.size() : exp_q.size();
    na = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
    chk({tag, " nbytes"}, got_b.size(), exp_q.size());
    for (int i = 0; i < nb; i++) chk($sformatf("%s byte%0d", tag, i), got_b[i], exp_q[i]);
    chk({tag, " nreads"}, got_a.size(), exp_a.size());
    for (int i = 0; i < na; i++) chk($sformatf("%s addr%0d", tag, i), got_a[i], exp_a[i]);
  endtask

  // driver tasks
  task automatic pulse_start(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] wc);
    @(negedge clk);
    start = 1'b1; base_addr = base; word_count = wc;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit rnd, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (rnd) txready = 1'($urandom_range(0, 1));
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run_dump(input logic [ADDR_W-1:0] base, input int wc, input bit rnd,
                          input string tag);
    int d0;
    bit ok;
    build_exp(base, wc);
    clear_mon();
    d0 = done_cnt;
    pulse_start(base, CNT_W'(wc));
    chk({tag, " busy"}, busy, 1);
    wait_done(4000, rnd, ok);
    chk({tag, " done seen"}, ok, 1);
    txready = 1'b1;
    repeat (4) @(negedge clk);
    chk({tag, " done pulses"}, done_cnt - d0, 1);
    chk({tag, " busy after"}, busy, 0);
    compare_sb(tag);
  endtask

  task automatic reset_mid(input bit on_read, input string tag);
    bit seen;
    int d0;
    txready = 1'b1;
    pulse_start(12'h200, 6'd3);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = on_read ? mem_read_en : txclk;
    end
    chk({tag, " trigger"}, seen, 1);
    #2 nRST = 1'b0;
    #1;
    chk({tag, " txclk"}, txclk, 0);
    chk({tag, " rd_en"}, mem_read_en, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " addr"}, mem_addr, 0);
    @(negedge clk);
    nRST = 1'b1;
    clear_mon();
    d0 = done_cnt;
    repeat (30) @(negedge clk);
    chk({tag, " no bytes"}, got_b.size(), 0);
    chk({tag, " no done"}, done_cnt - d0, 0);
    chk({tag, " idle"}, dbg_state, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int c;
    for (int i = 0; i < 1024; i++) ram[i] = $urandom;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst rd_en", mem_read_en, 0);
    chk("rst addr", mem_addr, 0);
    chk("rst txdata", txdata, 0);
    chk("rst txclk", txclk, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    nRST = 1'b1;
    repeat (2) @(negedge clk);

    // single word, full-speed UART
    ram[12'h100 / 4] = 32'hDEADBEEF;
    txready = 1'b1;
    run_dump(12'h100, 1, 1'b0, "single");
    if (got_b.size() >= 4) begin
      chk("single first", got_b[0], 8'hEF);
      chk("single t0", got_t[0], start_cyc + 4);
      for (int i = 0; i < 3; i++) chk($sformatf("single gap%0d", i), got_t[i+1] - got_t[i], 2);
    end else chk("single count", got_b.size(), 4);

    // address wrap at the top of memory
    ram[12'hFFC / 4] = 32'h11223344;
    ram[0] = 32'h55667788;
    run_dump(12'hFFC, 2, 1'b0, "wrap");
    if (got_t.size() >= 5) chk("wrap word period", got_t[4] - got_t[0], 10);

    // unaligned base low bits are ignored
    run_dump(12'h0A7, 2, 1'b0, "unaligned");

    // backpressure: txready low for 20 cycles after capture
    txready = 1'b0;
    build_exp(12'h100, 1);
    clear_mon();
    pulse_start(12'h100, 6'd1);
    for (int i = 0; i < 20 && got_a.size() == 0; i++) @(negedge clk);
    chk("bp read", got_a.size(), 1);
    repeat (21) @(negedge clk);
    chk("bp no strobe", got_b.size(), 0);
    txready = 1'b1;
    c = cyc;
    wait_done(200, 1'b0, ok);
    chk("bp done", ok, 1);
    if (got_t.size() > 0) begin
      chk("bp latency", got_t[0], c + 1);
      chk("bp byte", got_b[0], 8'hEF);
    end else chk("bp strobe", got_t.size(), 1);
    compare_sb("bp");

    // zero-length dump
    run_dump(12'h010, 0, 1'b0, "zero");
`ifdef MEMDUMP_CHECKSUM_EN
    chk("zero done time", done_cyc, start_cyc + 4);
`else
    chk("zero done time", done_cyc, start_cyc + 2);
`endif

`ifdef MEMDUMP_CHECKSUM_EN
    ram[12'h040 / 4] = 32'h01020304;
    run_dump(12'h040, 1, 1'b0, "csum");
    if (got_b.size() == 5) chk("csum byte", got_b[4], 8'h04);
`endif

    // start pulsed again while busy is ignored
    build_exp(12'h300, 3);
    clear_mon();
    c = done_cnt;
    pulse_start(12'h300, 6'd3);
    repeat (5) @(negedge clk);
    pulse_start(12'h040, 6'd9);
    wait_done(500, 1'b0, ok);
    chk("rebusy done", ok, 1);
    repeat (4) @(negedge clk);
    chk("rebusy pulses", done_cnt - c, 1);
    compare_sb("rebusy");

    // random dumps with random UART backpressure
    for (int k = 0; k < 8; k++) begin
      run_dump(12'($urandom_range(0, 4095)), $urandom_range(0, 12), 1'b1,
               $sformatf("rand%0d", k));
    end

    // asynchronous reset mid-dump
    reset_mid(1'b0, "rst_tx");
    reset_mid(1'b1, "rst_rd");
    run_dump(12'h200, 2, 1'b1, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
